load_store_unit: RTL and testbench

Memory-access initiator between the CPU datapath and the word-organised data memory. Accepts byte/halfword/word load and store requests on a byte address through a valid/ready handshake, drives the memory's word interface (address, read strobe, write strobe, write data), and returns aligned, extended load data with a one-cycle response pulse. Sub-word stores use read-modify-write, because the memory writes only whole 32-bit words.

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the CPU-side request/response handshake and the word-organised
//   data memory port of the load/store unit.
//   Ports (signals):
//     req_valid, req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//     resp_valid, resp_rdata, resp_err
//     mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata
//   slave  : the load/store unit side.
//   master : the requester side (CPU datapath and memory model).
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte/halfword/word load-store initiator in front of a 32-bit word memory.
//   Sub-word stores are done as read-modify-write. Loads return the addressed
//   lane right-aligned and sign- or zero-extended.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : load_store_unit_if.slave (request, response and memory signals)
//   Optional feature: define MISALIGN_TRAP_EN to answer misaligned halfword/word
//   requests with resp_err=1 and no memory access.
//
//   state | meaning
//   IDLE  | ready for a request
//   RD    | memory read strobe; capture word for load or RMW merge
//   WR    | memory write strobe with final word
//   RESP  | one-cycle response pulse
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        we_q, signed_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q;
    logic        accept, misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data, merge_data;

    assign accept = bus.req_valid & bus.req_ready;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    always_comb begin
        misaligned = 1'b0;
        if (bus.req_size == 2'b01)
            misaligned = bus.req_addr[0];
        else if (bus.req_size[1])
            misaligned = (bus.req_addr[1:0] != 2'b00);
    end
    assign bus.resp_err = (state == RESP) & err_q;
`else
    assign misaligned   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned)
                        state_next = RESP;
                    else if (bus.req_we && bus.req_size[1])
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                bus.mem_rd = 1'b1;
                state_next = we_q ? WR : RESP;
            end
            WR: begin
                bus.mem_wr = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction; halfwords use only offset bit 1, so addr[0] is ignored
    // when misalignment is not trapped.
    assign byte_lane = bus.mem_rdata[{off_q, 3'b000} +: 8];
    assign half_lane = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        merge_data = bus.mem_rdata;
        case (size_q)
            2'b00: merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (off_q[1]) merge_data[31:16] = wdata_q[15:0];
                else          merge_data[15:0]  = wdata_q[15:0];
            end
            default: merge_data = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 2'b00;
            wdata_q        <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q          <= 1'b0;
`endif
        end else if (accept) begin
            we_q          <= bus.req_we;
            signed_q      <= bus.req_signed;
            size_q        <= bus.req_size;
            off_q         <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata;
            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
            // A word store goes straight to WR, so its data must already be
            // on mem_wdata; sub-word stores overwrite this with the merge.
            bus.mem_wdata <= bus.req_wdata;
`ifdef MISALIGN_TRAP_EN
            err_q         <= misaligned;
`endif
        end else if (state == RD) begin
            if (we_q) bus.mem_wdata  <= merge_data;
            else      bus.resp_rdata <= load_data;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus();
    load_store_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // memory model: preload port for the bench, write port for the DUT
    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)          tb_mem[pre_addr] <= pre_data;
        else if (bus.mem_wr) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:0]];

    int overlap  = 0;
    int resp_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_rd && bus.mem_wr) overlap <= overlap + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // results of one request
    int          r_resp_cyc, r_rd_cyc, r_wr_cyc, r_rd_cnt, r_wr_cnt, r_addr_bad;
    logic [31:0] r_rdata, r_wdata_at_wr;
    logic        r_err;

    // model expectations
    int          e_resp_cyc, e_rd_cyc, e_wr_cyc;
    logic [31:0] e_rdata, e_wdata;
    logic        e_err;
    logic [31:0] last_rdata = '0;

    function automatic int lane_shift(input logic [1:0] size, input logic [ADDR_W+1:0] addr);
        if (size == 2'b00) return 8 * int'(addr[1:0]);
        if (size == 2'b01) return 16 * int'(addr[1]);
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [ADDR_W+1:0] addr);
        logic [31:0] v;
        v = word >> lane_shift(size, addr);
        if (size == 2'b00) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                                input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (size >= 2) return wd;
        mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh   = lane_shift(size, addr);
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [ADDR_W+1:0] addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01) return addr[0];
        if (size >= 2)     return addr[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    task automatic predict(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        int idx;
        idx = int'(addr[9:2]);
        e_rd_cyc = -1; e_wr_cyc = -1; e_err = 1'b0; e_wdata = '0;
        if (model_misaligned(size, addr)) begin
            e_resp_cyc = 1; e_err = 1'b1;
        end else if (!we) begin
            e_rd_cyc = 1; e_resp_cyc = 2;
            last_rdata = model_load(ref_mem[idx], size, sgn, addr);
        end else if (size >= 2) begin
            e_wr_cyc = 1; e_resp_cyc = 2;
            e_wdata = wd; ref_mem[idx] = wd;
        end else begin
            e_rd_cyc = 1; e_wr_cyc = 2; e_resp_cyc = 3;
            e_wdata = model_store(ref_mem[idx], size, addr, wd);
            ref_mem[idx] = e_wdata;
        end
        e_rdata = last_rdata;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a[7:0]; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        int guard;
        @(negedge clk);
        bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        r_resp_cyc = -1; r_rd_cyc = -1; r_wr_cyc = -1;
        r_rd_cnt = 0; r_wr_cnt = 0; r_addr_bad = 0;
        r_rdata = 'x; r_err = 1'bx; r_wdata_at_wr = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.mem_rd) begin
                r_rd_cnt++;
                if (r_rd_cyc < 0) r_rd_cyc = n;
            end
            if (bus.mem_wr) begin
                r_wr_cnt++;
                if (r_wr_cyc < 0) r_wr_cyc = n;
                r_wdata_at_wr = bus.mem_wdata;
            end
            if ((bus.mem_rd || bus.mem_wr) && bus.mem_addr != addr[ADDR_W+1:2]) r_addr_bad++;
            if (bus.resp_valid) begin
                r_resp_cyc = n; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
            bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%b rv=%b err=%b rd=%b wr=%b, want 1 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_rd, bus.mem_wr);
        end
        total++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, want zeros",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_word_store_load();
        predict(1'b1, 2'b10, 1'b0, 18'h0044, 32'hDEAD_BEEF);
        do_req(1'b1, 2'b10, 1'b0, 18'h0044, 32'hDEAD_BEEF);
        total++;
        if (r_wr_cyc !== 1 || r_rd_cnt !== 0 || r_resp_cyc !== 2 || r_wdata_at_wr !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL word_store: got wr@%0d rds=%0d resp@%0d wdata=%h, want wr@1 rds=0 resp@2 wdata=deadbeef",
                     r_wr_cyc, r_rd_cnt, r_resp_cyc, r_wdata_at_wr);
        end
        total++;
        if (tb_mem[8'h11] !== 32'hDEAD_BEEF || r_addr_bad !== 0) begin
            bad++;
            $display("FAIL word_store_mem: got mem=%h addr_bad=%0d, want deadbeef 0", tb_mem[8'h11], r_addr_bad);
        end
        predict(1'b0, 2'b10, 1'b0, 18'h0044, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 18'h0044, 32'h0);
        total++;
        if (r_rd_cyc !== 1 || r_resp_cyc !== 2 || r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
            bad++;
            $display("FAIL word_load: got rd@%0d resp@%0d rdata=%h err=%b, want rd@1 resp@2 deadbeef 0",
                     r_rd_cyc, r_resp_cyc, r_rdata, r_err);
        end
    endtask

    task automatic test_byte_rmw();
        preload(8'h11, 32'h0000_000F);
        predict(1'b1, 2'b00, 1'b0, 18'h0046, 32'h0000_00AB);
        do_req(1'b1, 2'b00, 1'b0, 18'h0046, 32'h1234_56AB);
        total++;
        if (r_rd_cyc !== 1 || r_wr_cyc !== 2 || r_resp_cyc !== 3 || r_wdata_at_wr !== 32'h00AB_000F) begin
            bad++;
            $display("FAIL byte_rmw: got rd@%0d wr@%0d resp@%0d wdata=%h, want 1 2 3 00ab000f",
                     r_rd_cyc, r_wr_cyc, r_resp_cyc, r_wdata_at_wr);
        end
        total++;
        if (tb_mem[8'h11] !== 32'h00AB_000F || r_rdata !== e_rdata) begin
            bad++;
            $display("FAIL byte_rmw_mem: got mem=%h rdata=%h, want 00ab000f %h", tb_mem[8'h11], r_rdata, e_rdata);
        end
    endtask

    task automatic test_extension();
        preload(8'h11, 32'h80FF_7F01);
        predict(1'b0, 2'b00, 1'b1, 18'h0045, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 18'h0045, 32'h0);
        total++;
        if (r_rdata !== 32'h0000_007F || r_resp_cyc !== 2) begin
            bad++;
            $display("FAIL ext_sbyte: got %h resp@%0d, want 0000007f resp@2", r_rdata, r_resp_cyc);
        end
        do_req(1'b0, 2'b01, 1'b1, 18'h0046, 32'h0);
        total++;
        if (r_rdata !== 32'hFFFF_80FF) begin
            bad++;
            $display("FAIL ext_shalf: got %h, want ffff80ff", r_rdata);
        end
        predict(1'b0, 2'b01, 1'b0, 18'h0046, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 18'h0046, 32'h0);
        total++;
        if (r_rdata !== 32'h0000_80FF) begin
            bad++;
            $display("FAIL ext_uhalf: got %h, want 000080ff", r_rdata);
        end
    endtask

    task automatic test_misalign();
        int rd_before;
        rd_before = r_rd_cnt;
        predict(1'b0, 2'b10, 1'b0, 18'h0046, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 18'h0046, 32'h0);
`ifdef MISALIGN_TRAP_EN
        total++;
        if (r_resp_cyc !== 1 || r_err !== 1'b1 || r_rd_cnt !== 0 || r_wr_cnt !== 0 || r_rdata !== 32'h0000_80FF) begin
            bad++;
            $display("FAIL misalign_trap: got resp@%0d err=%b rds=%0d wrs=%0d rdata=%h, want 1 1 0 0 000080ff",
                     r_resp_cyc, r_err, r_rd_cnt, r_wr_cnt, r_rdata);
        end
`else
        total++;
        if (r_resp_cyc !== 2 || r_err !== 1'b0 || r_rd_cyc !== 1 || r_rdata !== 32'h80FF_7F01 || r_addr_bad !== 0) begin
            bad++;
            $display("FAIL misalign_plain: got resp@%0d err=%b rd@%0d rdata=%h addr_bad=%0d, want 2 0 1 80ff7f01 0",
                     r_resp_cyc, r_err, r_rd_cyc, r_rdata, r_addr_bad);
        end
`endif
        total++;
        if (r_rdata !== e_rdata || r_err !== e_err) begin
            bad++;
            $display("FAIL misalign_model: got rdata=%h err=%b, want %h %b", r_rdata, r_err, e_rdata, e_err);
        end
        if (rd_before < 0) $display("note: unexpected read count");
    endtask

    task automatic test_reset_mid_wr();
        int guard, resp_before;
        preload(8'h20, 32'h1234_5678);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 18'h0081; bus.req_wdata = 32'h0000_0099; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.mem_wr && guard < 6);
        total++;
        if (!bus.mem_wr) begin
            bad++;
            $display("FAIL rst_wr_reach: got mem_wr=%b after %0d cycles, want 1", bus.mem_wr, guard);
        end
        resp_before = resp_cnt;
        rst = 1'b1;
        #1;
        total++;
        if (bus.mem_wr !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_abort: got wr=%b ready=%b rv=%b, want 0 1 0", bus.mem_wr, bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        repeat (4) @(negedge clk);
        total++;
        if (tb_mem[8'h20] !== 32'h1234_5678 || resp_cnt !== resp_before || bus.resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_after: got mem=%h resps=%0d rdata=%h, want 12345678 %0d 0",
                     tb_mem[8'h20], resp_cnt - resp_before, bus.resp_rdata, 0);
        end
    endtask

    task automatic test_random();
        logic we, sgn;
        logic [1:0] size;
        logic [ADDR_W+1:0] addr;
        logic [31:0] wd;
        int mem_bad;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 18'($urandom_range(0, 255));
            wd   = $urandom;
            predict(we, size, sgn, addr, wd);
            do_req(we, size, sgn, addr, wd);
            total++;
            if (r_resp_cyc !== e_resp_cyc || r_rd_cyc !== e_rd_cyc || r_wr_cyc !== e_wr_cyc ||
                r_rdata !== e_rdata || r_err !== e_err || r_addr_bad !== 0 ||
                (e_wr_cyc > 0 && r_wdata_at_wr !== e_wdata)) begin
                bad++;
                $display("FAIL rand_%0d we=%b sz=%0d s=%b a=%h: got resp@%0d rd@%0d wr@%0d rdata=%h err=%b wd=%h ab=%0d, want %0d %0d %0d %h %b %h 0",
                         i, we, size, sgn, addr, r_resp_cyc, r_rd_cyc, r_wr_cyc, r_rdata, r_err,
                         r_wdata_at_wr, r_addr_bad, e_resp_cyc, e_rd_cyc, e_wr_cyc, e_rdata, e_err, e_wdata);
            end
        end
        mem_bad = 0;
        for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) mem_bad++;
        total++;
        if (mem_bad != 0) begin
            bad++;
            $display("FAIL rand_mem: got %0d differing words, want 0", mem_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic        q_we   [0:2];
        logic [17:0] q_addr [0:2];
        logic [31:0] q_wd   [0:2];
        logic [31:0] exp_rd [0:2];
        int          acc    [0:2];
        int idx, seen, ov0;
        logic take;
        preload(8'h30, 32'hA5A5_0001);
        q_we[0] = 1'b0; q_addr[0] = 18'h00C0; q_wd[0] = 32'h0;
        q_we[1] = 1'b1; q_addr[1] = 18'h00C4; q_wd[1] = 32'h5555_AAAA;
        q_we[2] = 1'b0; q_addr[2] = 18'h00C4; q_wd[2] = 32'h0;
        ov0 = overlap; idx = 0; seen = 0;
        @(negedge clk);
        bus.req_we = q_we[0]; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = q_addr[0]; bus.req_wdata = q_wd[0]; bus.req_valid = 1'b1;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.resp_valid && seen < 3) begin
                total++;
                if (bus.resp_rdata !== exp_rd[seen] || bus.resp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_resp_%0d: got rdata=%h err=%b, want %h 0", seen, bus.resp_rdata, bus.resp_err, exp_rd[seen]);
                end
                seen++;
            end
            take = bus.req_ready && idx < 3;
            @(posedge clk);
            #1;
            if (take) begin
                predict(q_we[idx], 2'b10, 1'b0, q_addr[idx], q_wd[idx]);
                exp_rd[idx] = e_rdata;
                acc[idx] = c;
                idx++;
                if (idx < 3) begin
                    bus.req_we = q_we[idx]; bus.req_addr = q_addr[idx]; bus.req_wdata = q_wd[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        total++;
        if (seen !== 3 || idx !== 3 || overlap !== ov0) begin
            bad++;
            $display("FAIL b2b_count: got resps=%0d accepts=%0d overlaps=%0d, want 3 3 0", seen, idx, overlap - ov0);
        end
        total++;
        if (idx == 3 && (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3)) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d %0d, want 3 3", acc[1] - acc[0], acc[2] - acc[1]);
        end
        total++;
        if (exp_rd[2] !== 32'h5555_AAAA || exp_rd[0] !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL b2b_model: got %h %h, want a5a50001 5555aaaa", exp_rd[0], exp_rd[2]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_extension();
        test_misalign();
        test_reset_mid_wr();
        test_back_to_back();
        test_random();
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL strobe_overlap: got %0d cycles with rd and wr, want 0", overlap);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
